// File: rtl/adder_pkg.sv
// Shared defaults and helpers for the registered carry-lookahead adder.
package adder_pkg;
  localparam int ADDER_N     = 27;
  localparam int ADDER_GROUP = 4;

  // Number of lookahead slices needed to cover n bits.
  function automatic int num_groups(input int n, input int g);
    return (n + g - 1) / g;
  endfunction
endpackage

// File: rtl/adder_reg_cla_group.sv
// One GROUP-bit carry-lookahead slice: local sums plus group generate/propagate.
module cla_group
  import adder_pkg::*;
#(
  parameter int GROUP = ADDER_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             G,
  output logic             P
);

  logic [GROUP-1:0] w_g, w_p, w_c;

  // Flattened lookahead: carry into bit i from any generating bit below it
  // that propagates all the way up, or from c0 through a full propagate run.
  function automatic logic la_carry(input logic [GROUP-1:0] g,
                                    input logic [GROUP-1:0] p,
                                    input logic c0, input int i);
    logic acc, run;
    acc = 1'b0;
    for (int j = 0; j < i; j++) begin
      run = g[j];
      for (int k = j + 1; k < i; k++) run = run & p[k];
      acc = acc | run;
    end
    run = c0;
    for (int k = 0; k < i; k++) run = run & p[k];
    return acc | run;
  endfunction

  assign w_g = a & b;
  assign w_p = a ^ b;

  for (genvar i = 0; i < GROUP; i++) begin : g_c
    assign w_c[i] = la_carry(w_g, w_p, cin, i);
  end

  assign s = w_p ^ w_c;
  assign G = la_carry(w_g, w_p, 1'b0, GROUP);
  assign P = &w_p;

endmodule

// File: rtl/adder_reg.sv
// N-bit unsigned adder, mod 2^N, built from lookahead slices with a registered sum.
// Define ADDER_IN_REG_EN to also register the operands (2-cycle latency).
module adder_reg
  import adder_pkg::*;
#(
  parameter int N     = ADDER_N,
  parameter int GROUP = ADDER_GROUP
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  output logic [N-1:0] sum
);

  localparam int NG = num_groups(N, GROUP);
  localparam int NP = NG * GROUP;

  logic [N-1:0]  w_op_a, w_op_b;
  logic [NP-1:0] w_a, w_b, w_s;
  logic [NG-1:0] w_gg, w_gp;
  logic [NG:0]   w_gc;
  logic [N-1:0]  r_sum;
  logic          w_unused;

`ifdef ADDER_IN_REG_EN
  logic [N-1:0] r_in1, r_in2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in1 <= '0;
      r_in2 <= '0;
    end else begin
      r_in1 <= input1;
      r_in2 <= input2;
    end
  end

  assign w_op_a = r_in1;
  assign w_op_b = r_in2;
`else
  assign w_op_a = input1;
  assign w_op_b = input2;
`endif

  // Pad bits are zero so they never generate or propagate into real bits.
  assign w_a = NP'(w_op_a);
  assign w_b = NP'(w_op_b);

  assign w_gc[0] = 1'b0;

  for (genvar i = 0; i < NG; i++) begin : g_slice
    cla_group #(.GROUP(GROUP)) u_grp (
      .a   (w_a[i*GROUP +: GROUP]),
      .b   (w_b[i*GROUP +: GROUP]),
      .cin (w_gc[i]),
      .s   (w_s[i*GROUP +: GROUP]),
      .G   (w_gg[i]),
      .P   (w_gp[i])
    );
    assign w_gc[i+1] = w_gg[i] | (w_gp[i] & w_gc[i]);
  end

  // Carry-out and pad-region sum bits are intentionally discarded.
  assign w_unused = ^{w_s, w_gc[NG]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sum <= '0;
    else     r_sum <= w_s[N-1:0];
  end

  assign sum = r_sum;

endmodule

// File: tb/tb_adder_reg.sv
// Scoreboard bench for adder_reg: driver pushes expected sums, monitor pops on each valid slot.
module tb_adder_reg;
  localparam int N = 27;
`ifdef ADDER_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] input1 = '0, input2 = '0;
  logic [N-1:0] sum;

  logic           drv_vld = 1'b0;
  logic [LAT-1:0] vld_pipe;
  logic [N-1:0]   exp_q[$];
  int             n_checks = 0;
  int             n_errors = 0;

  adder_reg #(.N(N), .GROUP(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .input1 (input1),
    .input2 (input2),
    .sum    (sum)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: sum=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Tracks which output slots carry a result the scoreboard owns.
  always @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= (vld_pipe << 1) | LAT'(drv_vld);
  end

  always @(posedge clk) begin
    #1;
    if (!rst && vld_pipe[LAT-1]) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard_underflow: sum=%h with no expected entry", sum);
      end else begin
        check("stream", sum, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] exp);
    @(negedge clk);
    rst     = 1'b0;
    input1  = a;
    input2  = b;
    drv_vld = 1'b1;
    exp_q.push_back(exp);
  endtask

  initial begin : stim
    logic [53:0]  pat;
    logic [N:0]   wide;

    // Reset held with live operands: output must stay zero across edges.
    input1 = 27'h1234567;
    input2 = 27'h0000001;
    #1 check("reset_t0", sum, '0);
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", sum, '0);
    end

    drive(27'h1234567, 27'h0000001, 27'h1234568);
`ifdef ADDER_IN_REG_EN
    @(posedge clk); #1 check("inreg_first_edge_zero", sum, '0);
`endif
    drive(27'h0000000, 27'h4000000, 27'h4000000);
    drive(27'h0000000, 27'h6000000, 27'h6000000);
    drive(27'h7FFFFFF, 27'h0000001, 27'h0000000);
    drive(27'h7FFFFFF, 27'h7FFFFFF, 27'h7FFFFFE);
    drive(27'h5555555, 27'h2AAAAAB, 27'h0000000);
    drive(27'h000000F, 27'h0000001, 27'h0000010);

    // Filling-ones stream, one pair per cycle with no gaps.
    pat = '0;
    for (int k = 0; k < 54; k++) begin
      pat  = {pat[52:0], 1'b1};
      wide = {1'b0, pat[26:0]} + {1'b0, pat[53:27]};
      drive(pat[26:0], pat[53:27], wide[N-1:0]);

      if (k == 30) begin
        // Reset between edges: pending results are dropped.
        #2;
        rst     = 1'b1;
        drv_vld = 1'b0;
        exp_q.delete();
        #1 check("midreset_immediate", sum, '0);
        @(posedge clk); #1 check("midreset_hold", sum, '0);
      end
    end

    @(negedge clk);
    drv_vld = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adder_reg.md
Name: adder_reg

Overview:
- Parameterised N-bit unsigned adder with a registered output. Sum is modulo 2^N; the carry-out is discarded.
- Used as the datapath adder characterised by the energy-estimation flow. Operands arrive every clock; the registered result feeds downstream logic.
- Internally a 4-bit-group carry-lookahead structure, so carry-chain switching is representative of synthesised hardware.

Parameters:
- N, 27, operand and result width in bits (legal N >= 1).
- GROUP, 4, carry-lookahead group width in bits; the last group is zero-padded when N is not a multiple of GROUP.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- input1  input  N  unsigned operand A.
- input2  input  N  unsigned operand B.
- sum  output  N  registered (input1 + input2) mod 2^N.

Behaviour:
- Reset: while rst=1, sum=0 immediately, without waiting for a clock edge. On the first rising edge after rst falls, sum takes the sum of the operands present at that edge.
- Latency: 1 cycle. The operands sampled at rising edge k appear on sum after edge k and hold until edge k+1.
- Throughput: one new operand pair per cycle. There is no handshake and no valid or stall signal.
- Arithmetic: unsigned. Bit N of the true sum (carry-out) is dropped, so wrap-around is silent. Example: all-ones + 1 gives 0.
- Carry structure:
  - Per bit: g=a&b, p=a^b.
  - Per group: generate G and propagate P; the carry into group i+1 is G_i | (P_i & c_i), with c_0=0.
  - Within a group: carries are computed by lookahead from the group carry-in.
  - Sum bit: p ^ carry-in.
- Zero padding of the last group must not affect the result bits.
- X-handling: no reset dependence of the combinational path. With rst=0, sum depends only on the registered operands.
- Reset mid-operation: the pending result is lost, sum=0 immediately, and normal operation resumes on the first rising edge after deassertion.

Optional Feature:
- Macro ADDER_IN_REG_EN.
- Defined:
  - input1 and input2 are first captured in input registers, which reset asynchronously to 0.
  - The addition uses the registered operands, so total latency is 2 cycles.
  - After reset, sum stays 0 for the first edge, because the input registers held 0.
- Undefined: operands feed the adder combinationally and latency is 1 cycle, as in Behaviour.
- The port list is identical in both builds.

Decomposition:
- Shared package adder_pkg:
  - default N (27) and GROUP (4);
  - a function that computes the group count as ceil(N/GROUP).
- One sub-module, cla_group: GROUP-bit lookahead slice.
  - Inputs: a, b, cin.
  - Outputs: s, group generate G, group propagate P.
- adder_reg instantiates ceil(N/GROUP) slices plus the inter-group carry chain and the output register(s).

Test Plan:
- Reset: hold rst=1 with input1=27'h1234567, input2=27'h0000001 -> sum=0 throughout. Release rst -> sum=27'h1234568 after the next edge (after two edges with ADDER_IN_REG_EN).
- Single high bit: input1=0, input2=27'h4000000 -> sum=27'h4000000. Then input1=0, input2=27'h6000000 -> sum=27'h6000000.
- Full carry ripple / wrap: input1=27'h7FFFFFF, input2=27'h0000001 -> sum=27'h0000000.
- Both all-ones: input1=input2=27'h7FFFFFF -> sum=27'h7FFFFFE.
- Back-to-back stream: drive the 54-bit shifting-ones pattern each cycle.
  - Lower 27 bits go to input1, upper 27 bits to input2.
  - Each sum must equal the mod-2^27 sum of the pair driven one cycle earlier (two cycles with ADDER_IN_REG_EN), with no bubbles.
- Reset mid-stream: assert rst between clock edges during the stream -> sum=0 within the same timestep; the stream resumes correctly after deassertion.
